// File: rtl/deser_load_scheduler.sv
// Command/load scheduler: parses header+payload word stream into buffer writes and array compute starts.
// Optional load idle timeout enabled by defining DESER_LOAD_TIMEOUT_EN.
module deser_load_scheduler #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 12,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              wbuf_we,
  output logic [ADDR_W-1:0] wbuf_addr,
  output logic              abuf_we,
  output logic [ADDR_W-1:0] abuf_addr,
  output logic [DATA_W-1:0] buf_wdata,
  output logic              array_start,
  input  logic              array_done,
  input  logic              clear_err,
  output logic              busy,
  output logic              err,
  output logic [1:0]        err_code,
  output logic [15:0]       cmd_count
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_START, S_WAIT_DONE, S_ERR} state_t;

  state_t              state_q;
  logic                is_weight_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [15:0]         remain_q;
  logic                wbuf_we_q, abuf_we_q, array_start_q, busy_q, err_q;
  logic [ADDR_W-1:0]   wbuf_addr_q, abuf_addr_q;
  logic [DATA_W-1:0]   buf_wdata_q;
  logic [1:0]          err_code_q;
  logic [15:0]         cmd_count_q;

  logic [3:0]          hdr_op;
  logic [ADDR_W-1:0]   hdr_base;
  logic [15:0]         hdr_len;
  logic                err_keep_d;
  logic [1:0]          err_code_keep_d;

`ifdef DESER_LOAD_TIMEOUT_EN
  localparam int IDLE_W = $clog2(TIMEOUT + 1);
  logic [IDLE_W-1:0]   idle_q;
`endif

  // clear_err drops the sticky error first so a cause detected in the same cycle wins.
  always_comb begin
    hdr_op          = in_data[31:28];
    hdr_base        = ADDR_W'(in_data[27:16]);
    hdr_len         = in_data[15:0];
    err_keep_d      = err_q & ~clear_err;
    err_code_keep_d = clear_err ? '0 : err_code_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      is_weight_q   <= 1'b0;
      addr_q        <= '0;
      remain_q      <= '0;
      wbuf_we_q     <= 1'b0;
      abuf_we_q     <= 1'b0;
      wbuf_addr_q   <= '0;
      abuf_addr_q   <= '0;
      buf_wdata_q   <= '0;
      array_start_q <= 1'b0;
      busy_q        <= 1'b0;
      err_q         <= 1'b0;
      err_code_q    <= '0;
      cmd_count_q   <= '0;
`ifdef DESER_LOAD_TIMEOUT_EN
      idle_q        <= '0;
`endif
    end else begin
      wbuf_we_q     <= 1'b0;
      abuf_we_q     <= 1'b0;
      array_start_q <= 1'b0;
      err_q         <= err_keep_d;
      err_code_q    <= err_code_keep_d;
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            case (hdr_op)
              4'd1, 4'd2: begin
                if (hdr_len == 16'd0) begin
                  cmd_count_q <= cmd_count_q + 16'd1;
                end else begin
                  state_q     <= S_LOAD;
                  busy_q      <= 1'b1;
                  is_weight_q <= (hdr_op == 4'd1);
                  addr_q      <= hdr_base;
                  remain_q    <= hdr_len;
`ifdef DESER_LOAD_TIMEOUT_EN
                  idle_q      <= '0;
`endif
                end
              end
              4'd3: begin
                state_q       <= S_START;
                busy_q        <= 1'b1;
                array_start_q <= 1'b1;
              end
              default: begin
                state_q <= S_ERR;
                busy_q  <= 1'b1;
                err_q   <= 1'b1;
                if (!err_keep_d) err_code_q <= 2'd1;
              end
            endcase
          end
        end
        S_LOAD: begin
          if (in_valid) begin
            if (is_weight_q) begin
              wbuf_we_q   <= 1'b1;
              wbuf_addr_q <= addr_q;
            end else begin
              abuf_we_q   <= 1'b1;
              abuf_addr_q <= addr_q;
            end
            buf_wdata_q <= in_data;
            addr_q      <= addr_q + ADDR_W'(1);
            remain_q    <= remain_q - 16'd1;
`ifdef DESER_LOAD_TIMEOUT_EN
            idle_q      <= '0;
`endif
            if (remain_q == 16'd1) begin
              state_q     <= S_IDLE;
              busy_q      <= 1'b0;
              cmd_count_q <= cmd_count_q + 16'd1;
            end
          end
`ifdef DESER_LOAD_TIMEOUT_EN
          else if (idle_q == IDLE_W'(TIMEOUT - 1)) begin
            state_q <= S_ERR;
            err_q   <= 1'b1;
            if (!err_keep_d) err_code_q <= 2'd3;
          end else begin
            idle_q <= idle_q + IDLE_W'(1);
          end
`endif
        end
        // array_start is high during this state; a word here already counts as compute-time traffic.
        S_START: begin
          state_q <= S_WAIT_DONE;
          if (in_valid) begin
            err_q <= 1'b1;
            if (!err_keep_d) err_code_q <= 2'd2;
          end
        end
        S_WAIT_DONE: begin
          if (in_valid) begin
            err_q <= 1'b1;
            if (!err_keep_d) err_code_q <= 2'd2;
          end
          if (array_done) begin
            state_q     <= S_IDLE;
            busy_q      <= 1'b0;
            cmd_count_q <= cmd_count_q + 16'd1;
          end
        end
        S_ERR: begin
          if (clear_err) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign wbuf_we     = wbuf_we_q;
  assign wbuf_addr   = wbuf_addr_q;
  assign abuf_we     = abuf_we_q;
  assign abuf_addr   = abuf_addr_q;
  assign buf_wdata   = buf_wdata_q;
  assign array_start = array_start_q;
  assign busy        = busy_q;
  assign err         = err_q;
  assign err_code    = err_code_q;
  assign cmd_count   = cmd_count_q;

endmodule

// File: doc/deser_load_scheduler.md
Name: deser_load_scheduler

Overview:
- Command/load scheduler between the serial-link deserializer and the systolic-array buffers, in the core clock domain.
- Parses a stream of 32-bit words into commands: a header word, then the payload words for that command.
- Writes each payload word into the weight or activation buffer at sequential addresses.
- Issues a start pulse to the array and waits for its done signal. Reports errors and counts completed commands.

Parameters:
- DATA_W, 32: word width; must be ≥ 32.
- ADDR_W, 12: buffer address width.
- TIMEOUT, 1024: idle-cycle limit inside a load (used only when the optional feature is enabled).

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- in_data  in  DATA_W  deserialized word, already in the clk domain
- in_valid  in  1  one-cycle strobe per word
- wbuf_we  out  1  weight buffer write enable
- wbuf_addr  out  ADDR_W  weight buffer write address
- abuf_we  out  1  activation buffer write enable
- abuf_addr  out  ADDR_W  activation buffer write address
- buf_wdata  out  DATA_W  write data shared by both buffers
- array_start  out  1  one-cycle compute start pulse
- array_done  in  1  compute-complete pulse from the array
- clear_err  in  1  clears the sticky error state
- busy  out  1  high in any state other than IDLE
- err  out  1  sticky error flag
- err_code  out  2  cause: 1 = bad opcode, 2 = word during compute, 3 = timeout
- cmd_count  out  16  completed commands, wraps at 2^16

Behaviour:
- Reset values: all outputs 0, state IDLE. Reset asserted mid-load aborts the command immediately; no further writes occur.
- All outputs are registered.
- Header fields: [31:28] opcode, [27:16] base address (low ADDR_W bits used), [15:0] payload length N.
- Opcodes: 1 = load weights, 2 = load activations, 3 = start compute. Any other opcode is illegal.
- IDLE, on in_valid, decodes the header:
  - opcode 1 or 2 with N > 0 → LOAD; address counter = base, remaining = N.
  - opcode 1 or 2 with N = 0 → no writes; cmd_count += 1; stay IDLE.
  - opcode 3 → START; N is ignored.
  - illegal opcode → ERR, err_code = 1.
- LOAD: each in_valid produces a write the next cycle:
  - we (wbuf_we or abuf_we per opcode) = 1 for exactly one cycle, addr = current address, buf_wdata = in_data.
  - Address then increments modulo 2^ADDR_W (wraps silently); remaining decrements.
  - The write of the last word (remaining = 1) coincides with the return to IDLE and cmd_count += 1.
  - Back-to-back in_valid every cycle is supported with no stalls.
- START: array_start = 1 for one cycle → WAIT_DONE.
- WAIT_DONE: on array_done → IDLE, cmd_count += 1.
  - in_valid while in WAIT_DONE: the word is dropped, err = 1, err_code = 2, and the block stays in WAIT_DONE.
  - array_done still completes the command normally, and err is not cleared by completion.
- array_done outside WAIT_DONE is ignored.
- ERR: all in_valid words are ignored and busy = 1. Exit to IDLE only when clear_err = 1, which also clears err and err_code.
- clear_err in other states clears err and err_code only; if in_valid arrives in the same WAIT_DONE cycle, the new error wins.
- Error priority: if several errors are detected in the same cycle, the first detected cause sets err_code; later causes do not overwrite it while err = 1.
- Only one of wbuf_we and abuf_we is ever high in a given cycle.

Optional Feature:
- Macro: DESER_LOAD_TIMEOUT_EN.
- Defined:
  - An idle counter runs in LOAD and resets on every in_valid.
  - When it reaches TIMEOUT cycles without in_valid → ERR, err = 1, err_code = 3. The partial load is not counted in cmd_count.
- Undefined: no counter exists; LOAD waits indefinitely and err_code 3 never occurs.

Test Plan:
- Weight load: header 0x1010_0003 then words A, B, C on consecutive cycles → wbuf_we on 3 consecutive cycles at addresses 0x010, 0x011, 0x012 with data A, B, C; abuf_we stays 0; cmd_count = 1; busy falls with the last write.
- Wrap and zero length: with ADDR_W = 12, header 0x2FFF_0002 plus 2 words → abuf writes at 0xFFF then 0x000. Then header 0x1000_0000 → no writes, cmd_count increments, busy stays 0.
- Compute: header 0x3000_0000 → array_start pulses once and busy = 1. A word sent during WAIT_DONE → err = 1, err_code = 2. array_done → IDLE, cmd_count increments, err remains 1.
- Illegal opcode: header 0x7000_0004 → ERR, err_code = 1; the following 4 words cause no writes. clear_err → IDLE, err = 0; a subsequent valid header is processed normally.
- Reset mid-load: header 0x1000_0008 and 3 words, then assert rst_n low → all outputs 0; after release, the next word is decoded as a header.
- With DESER_LOAD_TIMEOUT_EN and TIMEOUT = 16: header 0x2000_0004, 1 word, then silence → ERR with err_code = 3 exactly 16 cycles after the last in_valid; cmd_count unchanged.
